// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with level reporting, programmable almost flags, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through reads.
module sync_fifo_thresh #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_L    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_level;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;

    // Extra pointer MSB lets the plain difference span 0..DEPTH.
    assign w_level = r_wptr - r_rptr;
    assign w_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign w_raddr = r_rptr[ADDR_WIDTH-1:0];
    assign w_full  = (w_level == DEPTH_L);
    assign w_empty = (w_level == '0);

    // Flush wins over traffic in the same cycle.
    assign w_wr_en = winc && !w_full  && !clr;
    assign w_rd_en = rinc && !w_empty && !clr;

    assign level        = w_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_level >= AF_L);
    assign almost_empty = (w_level <= AE_L);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en)         r_wptr      <= r_wptr + PTR_ONE;
            if (w_rd_en)         r_rptr      <= r_rptr + PTR_ONE;
            if (winc && w_full)  r_overflow  <= 1'b1;
            if (rinc && w_empty) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) r_mem[w_waddr] <= wdata;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rvalid;

            // Flush drops rvalid but keeps the last word on rdata.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (clr) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_en;
                    if (w_rd_en) r_rdata <= r_mem[w_raddr];
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end else begin : g_fwft_read
            assign rdata  = r_mem[w_raddr];
            assign rvalid = !w_empty;
        end
    endgenerate
endmodule
